// File: rtl/koggestone_adder8.sv
// 8-bit Kogge-Stone adder tile: structural three-level prefix tree feeding a
// registered sum on uo_out. The bidirectional pins are permanently inputs.

// Black cell: full prefix operator (G,P) o (G',P') = (G | P&G', P&P').
module ks_black_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);
  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;
endmodule

// Gray cell: generate-only. Used where the group already reaches bit 0, so
// with carry-in tied low the group propagate is never consumed again.
module ks_gray_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  output logic g_out
);
  assign g_out = g_hi | (p_hi & g_lo);
endmodule

// One prefix level of span SPAN across all 8 nodes.
module ks_level #(
  parameter int SPAN = 1
) (
  input  logic [7:0] g_in,
  input  logic [7:0] p_in,
  output logic [7:0] g_out,
  output logic [7:0] p_out
);
  for (genvar i = 0; i < 8; i++) begin : g_node
    if (i < SPAN) begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end else if (i < 2 * SPAN) begin : g_gray
      ks_gray_cell u_gray (
        .g_hi (g_in[i]),
        .p_hi (p_in[i]),
        .g_lo (g_in[i-SPAN]),
        .g_out(g_out[i])
      );
      // Group spans down to bit 0; its propagate is dead from here on.
      assign p_out[i] = 1'b0;
    end else begin : g_black
      ks_black_cell u_black (
        .g_hi (g_in[i]),
        .p_hi (p_in[i]),
        .g_lo (g_in[i-SPAN]),
        .p_lo (p_in[i-SPAN]),
        .g_out(g_out[i]),
        .p_out(p_out[i])
      );
    end
  end
endmodule

module koggestone_adder8_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
  logic [7:0] s;
  logic [7:0] sum_d, sum_q;
  logic       unused_carry;

  assign g0 = ui_in & uio_in;
  assign p0 = ui_in ^ uio_in;

  ks_level #(.SPAN(1)) u_lvl1 (.g_in(g0), .p_in(p0), .g_out(g1), .p_out(p1));
  ks_level #(.SPAN(2)) u_lvl2 (.g_in(g1), .p_in(p1), .g_out(g2), .p_out(p2));
  ks_level #(.SPAN(4)) u_lvl3 (.g_in(g2), .p_in(p2), .g_out(g3), .p_out(p3));

  // g3[i] is the carry into bit i+1; g3[7] is the (unexported) carry-out.
  assign s = p0 ^ {g3[6:0], 1'b0};
  assign unused_carry = ^{g3[7], p3};

  always_comb begin
    sum_d = sum_q;
    if (ena) sum_d = s;
  end

  // rst_n is active-high here; it overrides ena.
  always_ff @(posedge clk) begin
    if (rst_n) sum_q <= 8'h00;
    else       sum_q <= sum_d;
  end

  assign uo_out  = sum_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_koggestone_adder8_core.sv
// Randomised self-checking bench for koggestone_adder8_core against an
// arithmetic reference with one-cycle latency.
module tb_koggestone_adder8_core;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_drv;
  logic       loop_en;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  assign uio_in = loop_en ? uio_out : uio_drv;

  koggestone_adder8_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ena = 1'b1; loop_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      ui_in = 8'($urandom); uio_drv = 8'($urandom);
      tick();
      n_checks++;
      if (uo_out !== 8'h00) begin
        n_fail++; $display("FAIL reset_uo_out cycle %0d: got %h want 00", c, uo_out);
      end
      n_checks++;
      if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
        n_fail++; $display("FAIL reset_uio cycle %0d: oe %h out %h want 00/00", c, uio_oe, uio_out);
      end
    end
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'h03; uio_drv = 8'h05;
    tick();
    n_checks++;
    if (uo_out !== 8'h08) begin
      n_fail++; $display("FAIL first_after_reset: got %h want 08", uo_out);
    end
  endtask

  task automatic test_corners();
    logic [7:0] ta [6];
    logic [7:0] tb [6];
    logic [7:0] te [6];
    ta = '{8'hFF, 8'h7F, 8'h0F, 8'hFF, 8'h80, 8'hAA};
    tb = '{8'h01, 8'h01, 8'h01, 8'hFF, 8'h80, 8'h55};
    te = '{8'h00, 8'h80, 8'h10, 8'hFE, 8'h00, 8'hFF};
    ena = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ui_in = ta[k]; uio_drv = tb[k];
      tick();
      n_checks++;
      if (uo_out !== te[k]) begin
        n_fail++; $display("FAIL corner %h+%h: got %h want %h", ta[k], tb[k], uo_out, te[k]);
      end
    end
  endtask

  task automatic test_enable_hold();
    ena = 1'b1; ui_in = 8'h12; uio_drv = 8'h34;
    tick();
    n_checks++;
    if (uo_out !== 8'h46) begin
      n_fail++; $display("FAIL hold_load: got %h want 46", uo_out);
    end
    ena = 1'b0; ui_in = 8'h01; uio_drv = 8'h01;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (uo_out !== 8'h46) begin
        n_fail++; $display("FAIL hold_frozen cycle %0d: got %h want 46", c, uo_out);
      end
    end
    ena = 1'b1;
    tick();
    n_checks++;
    if (uo_out !== 8'h02) begin
      n_fail++; $display("FAIL hold_release: got %h want 02", uo_out);
    end
  endtask

  task automatic test_loopback();
    loop_en = 1'b1; ena = 1'b1;
    for (int a = 0; a < 256; a++) begin
      ui_in = 8'(a);
      tick();
      n_checks++;
      if (uo_out !== 8'(a)) begin
        n_fail++; $display("FAIL loopback A=%0d: got %h want %h", a, uo_out, 8'(a));
      end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_random();
    int exp_sum;
    int a, b;
    exp_sum = 0;
    // Bring the model into step with the DUT via a known reset.
    rst_n = 1'b1; tick(); rst_n = 1'b0;
    for (int c = 0; c < 12000; c++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      ui_in = 8'(a); uio_drv = 8'(b);
      ena = ($urandom_range(0, 9) != 0);
      rst_n = (c >= 6000 && c < 6003);
      if (rst_n)    exp_sum = 0;
      else if (ena) exp_sum = (a + b) % 256;
      tick();
      n_checks++;
      if (uo_out !== 8'(exp_sum)) begin
        n_fail++;
        $display("FAIL random c=%0d A=%h B=%h ena=%b rst=%b: got %h want %h",
                 c, a[7:0], b[7:0], ena, rst_n, uo_out, 8'(exp_sum));
      end
    end
    rst_n = 1'b0;
  endtask

  task automatic test_back_to_back();
    ena = 1'b1; rst_n = 1'b0;
    for (int a = 0; a < 256; a += 17) begin
      for (int b = 0; b < 256; b += 15) begin
        ui_in = 8'(a); uio_drv = 8'(b);
        tick();
        n_checks++;
        if (uo_out !== 8'((a + b) % 256)) begin
          n_fail++; $display("FAIL b2b %0d+%0d: got %h want %h", a, b, uo_out, 8'((a + b) % 256));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_drv = 8'h00; loop_en = 1'b0;
    test_reset();
    test_corners();
    test_enable_hold();
    test_loopback();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/koggestone_adder8_core.md
# koggestone_adder8_core

8-bit Kogge-Stone parallel-prefix adder packaged as a TinyTapeout user tile (`tt_um_koggestone_adder8`). Operand A arrives on the dedicated inputs and operand B on the bidirectional pins, which are permanently configured as inputs. The sum is computed combinationally through a three-level prefix tree and registered onto the dedicated outputs. The block is a standalone tile directly under the TinyTapeout harness.

## Interface
- No parameters; width fixed at 8.
- `clk`  input  1  single system clock; all state on rising edge.
- `rst_n`  input  1  reset, synchronous, active-high (asserted when 1), sampled on rising `clk`. The harness port name is retained; polarity is fixed as stated.
- `ena`  input  1  tile enable; 1 = result register updates, 0 = register holds.
- `ui_in`  input  8  operand A[7:0].
- `uio_in`  input  8  operand B[7:0].
- `uo_out`  output  8  registered SUM[7:0] = (A + B) mod 256.
- `uio_out`  output  8  constant 8'h00.
- `uio_oe`  output  8  constant 8'h00 (all bidirectional pins are inputs).

## Operation
- Carry-in is 0. Carry-out is computed internally but is not exported. The result wraps modulo 256.
- Bit-level signals: `g[i] = A[i] & B[i]` and `p[i] = A[i] ^ B[i]`.
- Prefix operator `(G,P) o (G',P') = (G | P&G', P&P')`.
- Level 1 (span 1): node i combines with node i-1 for i>=1; nodes i<1 pass through.
- Level 2 (span 2): node i combines with node i-2 for i>=2; other nodes pass through.
- Level 3 (span 4): node i combines with node i-4 for i>=4; other nodes pass through.
- After level 3, `G[i]` is the carry out of bit i: c[i+1] = G[i].
- Sum: `s[0] = p[0]` and `s[i] = p[i] ^ G[i-1]` for i=1..7.
- Prefix nodes are structural (explicit black/gray cells, log2(8)=3 levels). A behavioural `+` is not allowed in the datapath.
- Result register `sum_q[7:0]` drives `uo_out`:
  - rst_n=1: sum_q <= 8'h00. Reset takes priority over `ena`.
  - rst_n=0 and ena=1: sum_q <= s.
  - rst_n=0 and ena=0: sum_q holds.
- `uio_out` and `uio_oe` are tied to 0 at all times, including during reset.
- `uio_out` may be looped back to `uio_in` externally. In that case B=0 and `uo_out` follows A.

## Timing
- Latency: one cycle. Operands sampled at rising edge N appear on `uo_out` after edge N. Operands are not registered separately.
- Throughput: one new addition per cycle while ena=1.
- Reset value: `uo_out`=8'h00, `uio_out`=8'h00, `uio_oe`=8'h00.
- Reset asserted mid-stream clears `uo_out` on the next edge. The first valid result appears on the edge after reset deasserts with ena=1.
- Combinational path: 3 prefix levels plus the XOR sum stage, which must close timing within one `clk` period.
- No handshake. Inputs must be stable around the rising edge.
- Toggling `ena` freezes and unfreezes the output without losing the held value.

## Test plan
- Reset: rst_n=1 for 2 cycles with arbitrary inputs -> `uo_out`=8'h00, `uio_oe`=8'h00, `uio_out`=8'h00. After rst_n=0, ena=1, A=8'h03, B=8'h05 -> `uo_out`=8'h08 one cycle later.
- Carry ripple across the full width: A=8'hFF, B=8'h01 -> `uo_out`=8'h00. A=8'h7F, B=8'h01 -> 8'h80. A=8'h0F, B=8'h01 -> 8'h10.
- Wrap and maximum: A=8'hFF, B=8'hFF -> 8'hFE. A=8'h80, B=8'h80 -> 8'h00. A=8'hAA, B=8'h55 -> 8'hFF.
- Enable hold: load A=8'h12, B=8'h34 (-> 8'h46), then ena=0 and change to A=8'h01, B=8'h01 -> `uo_out` stays 8'h46. Set ena=1 -> next cycle 8'h02.
- Loopback mode (`uio_out` wired to `uio_in`): sweep A=0..255 -> `uo_out` equals A delayed by one cycle.
- Exhaustive/random: all 65536 (A,B) pairs, or at least 10k random pairs, checked against a (A+B)&8'hFF reference with one-cycle delay. Include a synchronous reset pulse mid-sweep -> output is 0 for exactly the reset cycles.
